// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC accumulate/buffer engine.
package mac_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int unsigned MaxDataW = 32;
    localparam int unsigned MaxAccW  = 64;

    // Picks acc[shift +: data_w]; with sat set, any higher bit clamps to all-ones.
    function automatic logic [MaxDataW-1:0] scale_result(
        input logic [MaxAccW-1:0] acc,
        input int unsigned        shift,
        input int unsigned        data_w,
        input bit                 sat
    );
        logic [MaxAccW-1:0] shifted;
        logic [MaxAccW-1:0] mask;
        shifted = acc >> shift;
        mask    = (MaxAccW'(1) << data_w) - MaxAccW'(1);
        if (sat && ((shifted & ~mask) != '0)) begin
            return MaxDataW'(mask);
        end
        return MaxDataW'(shifted & mask);
    endfunction

    function automatic bit params_ok(
        input int unsigned data_w,
        input int unsigned acc_w,
        input int unsigned taps,
        input int unsigned depth
    );
        return (data_w >= 1) && (data_w <= MaxDataW) && (acc_w >= 2 * data_w) &&
               (acc_w <= MaxAccW) && (taps >= 1) && (depth >= 1);
    endfunction

endpackage

// File: rtl/mac_result_buffer.sv
// DEPTH x DATA_W result slots with indexed write, synchronous clear and packed read-out.
module mac_result_buffer
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned IDX_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we_i,
    input  logic                    clr_i,
    input  logic [IDX_W-1:0]        idx_i,
    input  logic [DATA_W-1:0]       data_i,
    output logic [DEPTH*DATA_W-1:0] packed_o
);

    logic [DATA_W-1:0] slot_q [DEPTH];
    logic [DATA_W-1:0] slot_d [DEPTH];

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            slot_d[i] = slot_q[i];
            if (clr_i) begin
                slot_d[i] = '0;
            end else if (we_i && (idx_i == IDX_W'(i))) begin
                slot_d[i] = data_i;
            end
        end
    end

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_pack
        assign packed_o[g*DATA_W +: DATA_W] = slot_q[g];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

endmodule

// File: rtl/mac_acc_buf.sv
// Multiply-accumulate engine: TAPS products per result, DEPTH results per packed output word.
module mac_acc_buf
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ACC_W     = 20,
    parameter int unsigned TAPS      = 9,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned RES_SHIFT = 8,
    parameter int unsigned SATURATE  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            img_pixel,
    input  logic [DATA_W-1:0]            filter_value,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DEPTH*DATA_W-1:0]      out,
    output logic [$clog2(DEPTH+1)-1:0]   out_count
);

    localparam int unsigned TapW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    if (!params_ok(DATA_W, ACC_W, TAPS, DEPTH)) begin : g_param_check
        $error("mac_acc_buf: illegal parameter combination");
    end

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [TapW-1:0]   tap_q, tap_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    acc_sum, acc_eff;
    logic [DATA_W-1:0]   scaled;
    logic beat, last_tap, flush_act, commit, last_slot, handoff;

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_count = cnt_q;

    always_comb begin
        prod      = (2*DATA_W)'(img_pixel) * (2*DATA_W)'(filter_value);
        acc_sum   = acc_q + ACC_W'(prod);
        beat      = in_valid && in_ready;
        acc_eff   = beat ? acc_sum : acc_q;
        last_tap  = beat && (tap_q == TapW'(TAPS - 1));
        flush_act = flush && in_ready;
        // A flush commits only when the partial result holds at least one tap.
        commit    = last_tap || (flush_act && (beat || (tap_q != '0)));
        last_slot = (ptr_q == PtrW'(DEPTH - 1));
        handoff   = out_valid && out_ready;
        scaled    = DATA_W'(scale_result(MaxAccW'(acc_eff), RES_SHIFT, DATA_W, SATURATE != 0));
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        tap_d   = tap_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (state_q == ACCUM) begin
            if (commit) begin
                acc_d = '0;
                tap_d = '0;
                cnt_d = cnt_q + CntW'(1);
                if (last_slot) begin
                    ptr_d   = '0;
                    state_d = HOLD;
                end else begin
                    ptr_d = ptr_q + PtrW'(1);
                end
            end else if (beat) begin
                acc_d = acc_sum;
                tap_d = tap_q + TapW'(1);
            end
            if (flush_act && (commit || (cnt_q != '0))) begin
                ptr_d   = '0;
                state_d = HOLD;
            end
        end else if (handoff) begin
            state_d = ACCUM;
            ptr_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            tap_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            tap_q   <= tap_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    mac_result_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (PtrW)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .we_i     (commit && (state_q == ACCUM)),
        .clr_i    (handoff),
        .idx_i    (ptr_q),
        .data_i   (scaled),
        .packed_o (out)
    );

endmodule

// File: tb/tb_mac_acc_buf.sv
// Directed and random stimulus for mac_acc_buf (truncating and saturating builds) vs. a sum-of-products model.
module tb_mac_acc_buf;

    localparam int DW = 8;
    localparam int AW = 20;
    localparam int TP = 9;
    localparam int DP = 4;
    localparam int SH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid, flush, out_ready;
    logic [DW-1:0] img_pixel, filter_value;

    logic              rdy_t, vld_t, rdy_s, vld_s;
    logic [DP*DW-1:0]  out_t, out_s;
    logic [2:0]        cnt_t, cnt_s;

    mac_acc_buf #(.DATA_W(DW), .ACC_W(AW), .TAPS(TP), .DEPTH(DP), .RES_SHIFT(SH), .SATURATE(0)) u_trunc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_t), .img_pixel(img_pixel),
        .filter_value(filter_value), .flush(flush), .out_valid(vld_t), .out_ready(out_ready),
        .out(out_t), .out_count(cnt_t)
    );

    mac_acc_buf #(.DATA_W(DW), .ACC_W(AW), .TAPS(TP), .DEPTH(DP), .RES_SHIFT(SH), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .img_pixel(img_pixel),
        .filter_value(filter_value), .flush(flush), .out_valid(vld_s), .out_ready(out_ready),
        .out(out_s), .out_count(cnt_s)
    );

    int errors = 0;
    int checks = 0;

    // Model: running sum of products, tap count, raw accumulator value per written slot.
    longint m_acc;
    int     m_taps, m_count;
    bit     m_hold;
    longint m_raw [DP];

    function automatic int scale(input longint acc, input bit sat);
        longint s;
        s = (acc % (longint'(1) << AW)) >> SH;
        if (sat && s > 255) return 255;
        return int'(s % 256);
    endfunction

    function automatic logic [31:0] exp_word(input bit sat);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < m_count; i++) w[i*8 +: 8] = 8'(scale(m_raw[i], sat));
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_rdy"}, 64'(rdy_t), 64'(!m_hold));
        check({tag, "_vld"}, 64'(vld_t), 64'(m_hold));
        check({tag, "_out"}, 64'(out_t), 64'(exp_word(1'b0)));
        check({tag, "_cnt"}, 64'(cnt_t), 64'(m_count));
        check({tag, "_s_rdy"}, 64'(rdy_s), 64'(!m_hold));
        check({tag, "_s_vld"}, 64'(vld_s), 64'(m_hold));
        check({tag, "_s_out"}, 64'(out_s), 64'(exp_word(1'b1)));
        check({tag, "_s_cnt"}, 64'(cnt_s), 64'(m_count));
    endtask

    task automatic commit_model();
        m_raw[m_count] = m_acc;
        m_count++;
        m_acc  = 0;
        m_taps = 0;
    endtask

    // Drive one cycle, advance the model, then compare #1 after the edge.
    task automatic step(input string tag, input bit v, input logic [7:0] p, input logic [7:0] f,
                        input bit fl, input bit ordy, input bit rstn);
        rst = rstn; in_valid = v; img_pixel = p; filter_value = f; flush = fl; out_ready = ordy;
        if (!rstn) begin
            m_acc = 0; m_taps = 0; m_count = 0; m_hold = 0;
        end else if (!m_hold) begin
            if (v) begin
                m_acc += longint'(p) * longint'(f);
                m_taps++;
            end
            if (m_taps == TP || (fl && m_taps > 0)) commit_model();
            if (m_count == DP || (fl && m_count > 0)) m_hold = 1;
        end else if (ordy) begin
            m_hold = 0; m_count = 0;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        m_acc = 0; m_taps = 0; m_count = 0; m_hold = 0;
        rst = 0; in_valid = 0; flush = 0; out_ready = 0; img_pixel = '0; filter_value = '0;

        step("reset", 0, 0, 0, 0, 0, 0);
        step("reset2", 1, 8'h10, 8'h10, 0, 0, 0);
        check("reset_out", 64'(out_t), 64'h0);

        // One full kernel of 16x16 then flush.
        for (int i = 0; i < 9; i++) step("k9", 1, 8'h10, 8'h10, 0, 0, 1);
        step("k9_flush", 0, 0, 0, 1, 0, 1);
        check("k9_word", 64'(out_t), 64'h9);
        check("k9_count", 64'(cnt_t), 64'd1);
        check("k9_valid", 64'(vld_t), 64'd1);
        step("k9_handoff", 0, 0, 0, 0, 1, 1);
        check("k9_cleared", 64'(out_t), 64'h0);

        // Four kernels of 255x255 fill the buffer.
        for (int i = 0; i < 36; i++) step("max", 1, 8'hFF, 8'hFF, 0, 0, 1);
        check("max_trunc", 64'(out_t), 64'hEEEEEEEE);
        check("max_sat", 64'(out_s), 64'hFFFFFFFF);
        check("max_valid", 64'(vld_t), 64'd1);

        // Backpressure: held output with in_valid asserted.
        for (int i = 0; i < 10; i++) step("bp", 1, 8'h33, 8'h44, 1, 0, 1);
        check("bp_ready", 64'(rdy_t), 64'd0);
        check("bp_hold", 64'(out_t), 64'hEEEEEEEE);
        step("bp_release", 1, 8'h33, 8'h44, 0, 1, 1);
        check("bp_rel_ready", 64'(rdy_t), 64'd1);
        check("bp_rel_out", 64'(out_t), 64'h0);

        // Partial kernel flushed, then a flush against an empty buffer.
        for (int i = 0; i < 3; i++) step("p3", 1, 8'h10, 8'h10, 0, 0, 1);
        step("p3_flush", 0, 0, 0, 1, 0, 1);
        check("p3_word", 64'(out_t), 64'h3);
        check("p3_count", 64'(cnt_t), 64'd1);
        step("p3_handoff", 0, 0, 0, 0, 1, 1);
        step("empty_flush", 0, 0, 0, 1, 0, 1);
        check("empty_ready", 64'(rdy_t), 64'd1);
        check("empty_valid", 64'(vld_t), 64'd0);

        // Flush coinciding with a beat includes that beat.
        step("fb_beat", 1, 8'h10, 8'h10, 0, 0, 1);
        step("fb_flush", 1, 8'h10, 8'h10, 1, 0, 1);
        check("fb_word", 64'(out_t), 64'h2);
        step("fb_handoff", 0, 0, 0, 0, 1, 1);

        // Reset mid-kernel discards the partial accumulation.
        for (int i = 0; i < 5; i++) step("mid", 1, 8'hFF, 8'hFF, 0, 0, 1);
        step("mid_rst", 1, 8'hFF, 8'hFF, 0, 0, 0);
        check("mid_rst_cnt", 64'(cnt_t), 64'd0);
        for (int i = 0; i < 9; i++) step("post", 1, 8'h10, 8'h10, 0, 0, 1);
        step("post_flush", 0, 0, 0, 1, 0, 1);
        check("post_word", 64'(out_t), 64'h9);
        step("post_handoff", 0, 0, 0, 0, 1, 1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step("rand", $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 99) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
